// File: rtl/npu_ram_stream_loader_pkg.sv
// Shared definitions for the NPU RAM stream loader: region ids, FSM states,
// and the active line width of each NPU RAM region.
package npu_ram_stream_loader_pkg;

  localparam int REGION_IMG32   = 0;
  localparam int REGION_IMG28   = 1;
  localparam int REGION_IMG24   = 2;
  localparam int REGION_IMG20   = 3;
  localparam int REGION_IMG16   = 4;
  localparam int REGION_IMG12   = 5;
  localparam int REGION_IMG8    = 6;
  localparam int REGION_IMG5    = 7;
  localparam int REGION_FILTER  = 8;
  localparam int REGION_WEIGHT  = 9;
  localparam int REGION_BIAS    = 10;
  localparam int REGION_RESULT  = 11;

  // Active bits per line; narrower regions consume the LSBs of line_data_o
  localparam int IMG_32_W  = 256;
  localparam int IMG_28_W  = 224;
  localparam int IMG_24_W  = 192;
  localparam int IMG_20_W  = 160;
  localparam int IMG_16_W  = 128;
  localparam int IMG_12_W  = 96;
  localparam int IMG_8_W   = 64;
  localparam int IMG_5_W   = 40;
  localparam int FLITER_W  = 200;
  localparam int WEIGHT_W  = 256;
  localparam int BIAS_W    = 128;
  localparam int RESULT_W  = 80;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FILL, ST_COMMIT, ST_FINISH, ST_RD_ADDR, ST_RD_DATA
  } state_t;

endpackage

// File: rtl/npu_ram_stream_loader_if.sv
// Stream input plus NPU RAM line-write bus of the loader.
// master = loader side, slave = bus bridge / RAM selector side.
interface npu_ram_stream_loader_if #(
  parameter int WORD_W     = 32,
  parameter int LINE_W     = 256,
  parameter int LINE_CNT   = 16,
  parameter int REGION_CNT = 12
);
  localparam int REG_W = $clog2(REGION_CNT);
  localparam int IDX_W = $clog2(LINE_CNT);

  logic              s_valid_i;
  logic              s_ready_o;
  logic [WORD_W-1:0] s_data_i;
  logic              s_last_i;
  logic              npu_ram_sel_o;
  logic              en_w_o;
  logic [REG_W-1:0]  region_o;
  logic [IDX_W-1:0]  w_line_o;
  logic [LINE_W-1:0] line_data_o;

  modport master (
    input  s_valid_i, s_data_i, s_last_i,
    output s_ready_o, npu_ram_sel_o, en_w_o, region_o, w_line_o, line_data_o
  );
  modport slave (
    output s_valid_i, s_data_i, s_last_i,
    input  s_ready_o, npu_ram_sel_o, en_w_o, region_o, w_line_o, line_data_o
  );
endinterface

// File: rtl/npu_line_packer.sv
// Word-to-line assembly buffer: word k lands at bits [k*WORD_W +: WORD_W].
module npu_line_packer #(
  parameter int WORD_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              wr_i,
  input  logic [WORD_W-1:0] data_i,
  output logic [LINE_W-1:0] line_o,
  output logic              full_o
);
  localparam int WPL   = LINE_W / WORD_W;
  localparam int CNT_W = (WPL > 1) ? $clog2(WPL) : 1;

  logic [CNT_W-1:0]  cnt_q;
  logic [LINE_W-1:0] line_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q  <= '0;
      line_q <= '0;
    end else if (wr_i) begin
      line_q[int'(cnt_q)*WORD_W +: WORD_W] <= data_i;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Asserted while the next write fills the last slot of the line
  assign full_o = (cnt_q == CNT_W'(WPL - 1));
  assign line_o = line_q;
endmodule

// File: rtl/npu_ram_stream_loader.sv
// Word-serial NPU RAM loader: packs a valid/ready stream into RAM line writes.
// Optional result readback port enabled by NPU_LOADER_READBACK_EN.
module npu_ram_stream_loader
  import npu_ram_stream_loader_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int LINE_W      = 256,
  parameter int LINE_CNT    = 16,
  parameter int REGION_CNT  = 12,
  parameter int RSLT_ADDR_W = 8,
  localparam int REG_W   = $clog2(REGION_CNT),
  localparam int IDX_W   = $clog2(LINE_CNT),
  localparam int LINES_W = IDX_W + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cfg_start_i,
  input  logic [REG_W-1:0]   cfg_region_i,
  input  logic [LINES_W-1:0] cfg_lines_i,
  npu_ram_stream_loader_if.master bus,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
`ifdef NPU_LOADER_READBACK_EN
  ,
  input  logic                   rd_req_i,
  input  logic [RSLT_ADDR_W-1:0] rd_addr_i,
  output logic [RSLT_ADDR_W-1:0] r_rslt_addr_o,
  input  logic [7:0]             result_i,
  output logic                   rd_valid_o,
  output logic [7:0]             rd_data_o
`endif
);
  state_t             st_q, st_d;
  logic [REG_W-1:0]   region_q, region_hold_q;
  logic [LINES_W-1:0] lines_q, line_cnt_q;
  logic [IDX_W-1:0]   line_hold_q;
  logic [LINE_W-1:0]  data_hold_q, line_buf;
  logic               last_seen_q, err_q, full, accept, final_line;

  assign accept     = (st_q == ST_FILL) && bus.s_valid_i;
  assign final_line = ((line_cnt_q + LINES_W'(1)) == lines_q);

  npu_line_packer #(.WORD_W(WORD_W), .LINE_W(LINE_W)) u_packer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (st_q == ST_COMMIT),
    .wr_i   (accept),
    .data_i (bus.s_data_i),
    .line_o (line_buf),
    .full_o (full)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) st_q <= ST_IDLE;
    else       st_q <= st_d;
  end

  always_comb begin
    st_d              = st_q;
    bus.s_ready_o     = (st_q == ST_FILL);
    bus.npu_ram_sel_o = (st_q == ST_FILL) || (st_q == ST_COMMIT);
    bus.en_w_o        = (st_q == ST_COMMIT);
    bus.region_o      = region_hold_q;
    bus.w_line_o      = line_hold_q;
    bus.line_data_o   = data_hold_q;
    busy_o            = (st_q != ST_IDLE);
    done_o            = (st_q == ST_FINISH);
    case (st_q)
      ST_IDLE: begin
        if (cfg_start_i) st_d = (cfg_lines_i == '0) ? ST_FINISH : ST_FILL;
`ifdef NPU_LOADER_READBACK_EN
        else if (rd_req_i) st_d = ST_RD_ADDR;
`endif
      end
      ST_FILL:   if (accept && (full || bus.s_last_i)) st_d = ST_COMMIT;
      ST_COMMIT: begin
        bus.region_o    = region_q;
        bus.w_line_o    = line_cnt_q[IDX_W-1:0];
        bus.line_data_o = line_buf;
        st_d = (final_line || last_seen_q) ? ST_FINISH : ST_FILL;
      end
      ST_FINISH: st_d = ST_IDLE;
`ifdef NPU_LOADER_READBACK_EN
      ST_RD_ADDR: st_d = ST_RD_DATA;
      ST_RD_DATA: st_d = ST_IDLE;
`endif
      default:   st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      region_q      <= '0;
      lines_q       <= '0;
      line_cnt_q    <= '0;
      last_seen_q   <= 1'b0;
      err_q         <= 1'b0;
      region_hold_q <= '0;
      line_hold_q   <= '0;
      data_hold_q   <= '0;
    end else begin
      case (st_q)
        ST_IDLE: if (cfg_start_i) begin
          region_q    <= cfg_region_i;
          lines_q     <= (cfg_lines_i > LINES_W'(LINE_CNT)) ? LINES_W'(LINE_CNT) : cfg_lines_i;
          line_cnt_q  <= '0;
          last_seen_q <= 1'b0;
          err_q       <= 1'b0;
        end
        ST_FILL: if (accept) begin
          last_seen_q <= bus.s_last_i;
          // s_last must coincide exactly with the final word of the final line
          if (bus.s_last_i != (full && final_line)) err_q <= 1'b1;
        end
        ST_COMMIT: begin
          line_cnt_q    <= line_cnt_q + LINES_W'(1);
          region_hold_q <= region_q;
          line_hold_q   <= line_cnt_q[IDX_W-1:0];
          data_hold_q   <= line_buf;
        end
        default: ;
      endcase
    end
  end

  assign err_o = err_q;

`ifdef NPU_LOADER_READBACK_EN
  logic [RSLT_ADDR_W-1:0] rd_addr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_addr_q     <= '0;
      r_rslt_addr_o <= '0;
      rd_valid_o    <= 1'b0;
      rd_data_o     <= '0;
    end else begin
      rd_valid_o <= (st_q == ST_RD_DATA);
      if (st_q == ST_IDLE && !cfg_start_i && rd_req_i) rd_addr_q <= rd_addr_i;
      if (st_q == ST_RD_ADDR) r_rslt_addr_o <= rd_addr_q;
      if (st_q == ST_RD_DATA) rd_data_o <= result_i;
    end
  end
`endif
endmodule

// File: tb/tb_npu_ram_stream_loader.sv
// Scoreboard bench for npu_ram_stream_loader: a line-level reference model
// queues expected writes/errors; a negedge monitor pops and compares.
module tb_npu_ram_stream_loader;
  localparam int WPL = 8;

  typedef struct {
    logic [3:0]   line;
    logic [3:0]   region;
    logic [255:0] data;
  } wr_t;

  logic       clk, rst_i, cfg_start_i;
  logic [3:0] cfg_region_i;
  logic [4:0] cfg_lines_i;
  logic       busy_o, done_o, err_o;
  int         checks = 0, errors = 0;
  wr_t        exp_w_q[$];
  bit         exp_err_q[$];

  npu_ram_stream_loader_if bus ();

`ifdef NPU_LOADER_READBACK_EN
  logic       rd_req_i, rd_valid_o;
  logic [7:0] rd_addr_i, r_rslt_addr_o, result_i, rd_data_o;
`endif

  npu_ram_stream_loader dut (
    .clk_i(clk), .rst_i(rst_i), .cfg_start_i(cfg_start_i),
    .cfg_region_i(cfg_region_i), .cfg_lines_i(cfg_lines_i), .bus(bus),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
`ifdef NPU_LOADER_READBACK_EN
    , .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .r_rslt_addr_o(r_rslt_addr_o),
    .result_i(result_i), .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Monitor: every line write and every done pulse must match the scoreboard
  always @(negedge clk) begin
    if (!rst_i) begin
      if (bus.en_w_o) begin
        if (exp_w_q.size() == 0) chk("unexpected_write", 1'b1, 1'b0);
        else begin
          wr_t e;
          e = exp_w_q.pop_front();
          chk("w_line", bus.w_line_o, e.line);
          chk("region", bus.region_o, e.region);
          chk("line_data", bus.line_data_o, e.data);
          chk("sel_during_write", bus.npu_ram_sel_o, 1'b1);
        end
      end
      if (done_o) begin
        if (exp_err_q.size() == 0) chk("unexpected_done", 1'b1, 1'b0);
        else chk("err_at_done", err_o, exp_err_q.pop_front());
        chk("sel_at_done", bus.npu_ram_sel_o, 1'b0);
      end
    end
  end

  task automatic pulse_start(input int region, input int lines);
    cfg_region_i = 4'(region);
    cfg_lines_i  = 5'(lines);
    cfg_start_i  = 1'b1;
    @(posedge clk); #1;
    cfg_start_i  = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input bit last, input bit eol, input bit stall);
    int n;
    if (stall) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    bus.s_valid_i = 1'b1;
    bus.s_data_i  = d;
    bus.s_last_i  = last;
    n = 0;
    @(negedge clk);
    while (!bus.s_ready_o && n < 100) begin @(negedge clk); n++; end
    if (!bus.s_ready_o) chk("ready_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    bus.s_valid_i = 1'b0;
    bus.s_last_i  = 1'b0;
    if (eol) begin
      @(negedge clk);
      chk("en_w_latency", bus.en_w_o, 1'b1);
      chk("ready_low_commit", bus.s_ready_o, 1'b0);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy_o && n < 3000) begin @(negedge clk); n++; end
    if (busy_o) chk("idle_timeout", busy_o, 1'b0);
    @(posedge clk); #1;
  endtask

  // Reference: words are grouped WPL per line, LSB first; the load stops at the
  // first s_last or after min(lines,16) lines; any mismatch of those is an error.
  task automatic run_load(input int region, input int lines, input int last_pos,
                          input bit stall, input bit seq, input bit poke);
    int L, total, consumed;
    logic [31:0] w[$];
    logic [255:0] d;
    wr_t e;
    L = (lines > 16) ? 16 : lines;
    total = L * WPL;
    consumed = (last_pos >= 0 && last_pos < total) ? last_pos + 1 : total;
    for (int i = 0; i < consumed; i++) w.push_back(seq ? 32'(i + 1) : $urandom);
    for (int ln = 0; ln * WPL < consumed; ln++) begin
      d = '0;
      for (int k = 0; k < WPL; k++)
        if (ln * WPL + k < consumed) d[k*32 +: 32] = w[ln*WPL + k];
      e.line = 4'(ln); e.region = 4'(region); e.data = d;
      exp_w_q.push_back(e);
    end
    exp_err_q.push_back((L != 0) && (last_pos != total - 1));
    pulse_start(region, lines);
    if (L == 0) begin
      @(negedge clk);
      chk("done_after_zero_start", done_o, 1'b1);
      chk("sel_zero_lines", bus.npu_ram_sel_o, 1'b0);
    end
    for (int i = 0; i < consumed; i++) begin
      if (poke && i == 2) pulse_start((region + 3) % 12, 5);
      send_word(w[i], i == last_pos, (i % WPL == WPL - 1) || (i == consumed - 1), stall);
    end
    wait_idle();
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; cfg_start_i = 1'b0; cfg_region_i = '0; cfg_lines_i = '0;
    bus.s_valid_i = 1'b0; bus.s_data_i = '0; bus.s_last_i = 1'b0;
`ifdef NPU_LOADER_READBACK_EN
    rd_req_i = 1'b0; rd_addr_i = '0; result_i = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", bus.s_ready_o, 1'b0);
    chk("rst_sel", bus.npu_ram_sel_o, 1'b0);
    chk("rst_en_w", bus.en_w_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_line_data", bus.line_data_o, '0);
    @(posedge clk); #1;
    rst_i = 1'b0;

    run_load(0, 2, 15, 1'b0, 1'b1, 1'b0);   // two full lines of 1..16, clean last
    run_load(2, 1, 7, 1'b1, 1'b0, 1'b1);    // stalls plus a start while busy
    run_load(4, 3, 9, 1'b0, 1'b1, 1'b0);    // early last on word 10
    run_load(6, 0, -1, 1'b0, 1'b0, 1'b0);   // zero lines
    run_load(9, 20, 127, 1'b1, 1'b0, 1'b0); // clamped to 16 lines
    run_load(1, 2, -1, 1'b0, 1'b0, 1'b0);   // missing last

    // Reset mid-load: line 0 written, then 5 words of line 1 are abandoned
    begin
      wr_t e;
      logic [31:0] w[$];
      for (int i = 0; i < 13; i++) w.push_back($urandom);
      e.line = 4'd0; e.region = 4'd5; e.data = '0;
      for (int k = 0; k < WPL; k++) e.data[k*32 +: 32] = w[k];
      exp_w_q.push_back(e);
      pulse_start(5, 2);
      for (int i = 0; i < 13; i++) send_word(w[i], 1'b0, i == WPL - 1, 1'b0);
      rst_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_busy", busy_o, 1'b0);
      chk("midrst_sel", bus.npu_ram_sel_o, 1'b0);
      chk("midrst_ready", bus.s_ready_o, 1'b0);
      chk("midrst_region", bus.region_o, '0);
      chk("midrst_line_data", bus.line_data_o, '0);
      chk("midrst_err", err_o, 1'b0);
      exp_w_q.delete();
      exp_err_q.delete();
      @(posedge clk); #1;
      rst_i = 1'b0;
      repeat (20) @(posedge clk);
      #1;
    end

    for (int t = 0; t < 12; t++) begin
      int region, lines, L, mode, lp;
      region = $urandom_range(0, 11);
      lines  = $urandom_range(0, 18);
      L      = (lines > 16) ? 16 : lines;
      mode   = $urandom_range(0, 3);
      if (L == 0 || mode == 3) lp = -1;
      else if (mode == 2)      lp = $urandom_range(0, L * WPL - 1);
      else                     lp = L * WPL - 1;
      run_load(region, lines, lp, 1'b1, 1'b0, t[0]);
    end

`ifdef NPU_LOADER_READBACK_EN
    rd_req_i = 1'b1; rd_addr_i = 8'h2A; result_i = 8'h5C;
    @(posedge clk); #1;
    rd_req_i = 1'b0;
    @(posedge clk); #1;
    chk("rb_addr", r_rslt_addr_o, 8'h2A);
    chk("rb_busy", busy_o, 1'b1);
    @(posedge clk); #1;
    chk("rb_valid", rd_valid_o, 1'b1);
    chk("rb_data", rd_data_o, 8'h5C);
    @(posedge clk); #1;
    chk("rb_valid_pulse", rd_valid_o, 1'b0);
`endif

    repeat (5) @(posedge clk);
    chk("pending_writes", 32'(exp_w_q.size()), 32'd0);
    chk("pending_dones", 32'(exp_err_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/npu_ram_stream_loader.md
Name: npu_ram_stream_loader

Overview:
Parametrised word-serial loader for the NPU RAM, replacing the wide per-region parallel load buses.
- Accepts a valid/ready word stream and packs words into RAM lines.
- Issues one-cycle line writes (enable, region, line index, line data) toward the NPU RAM selector.
- Holds the RAM-select grant while a load is in progress; sits between the system bus bridge and the NPU RAM selector.

Parameters:
WORD_W, 32, stream word width; LINE_W must be an integer multiple of it
LINE_W, 256, bits per NPU RAM line (widest region line; narrower regions use the LSBs)
LINE_CNT, 16, maximum lines per region; w_line_o width = clog2(LINE_CNT)
REGION_CNT, 12, number of loadable NPU RAM regions (img32..img5, filters, weights, biases, result)
RSLT_ADDR_W, 8, result readback address width (optional feature only)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
cfg_start_i  in  1  start-load pulse; sampled only in IDLE
cfg_region_i  in  clog2(REGION_CNT)  target region; captured at start
cfg_lines_i  in  clog2(LINE_CNT)+1  lines to load; captured at start
s_valid_i / s_ready_o  in / out  1  stream handshake; a transfer occurs when both are high on a rising edge
s_data_i  in  WORD_W  stream word
s_last_i  in  1  marks the final word of the load
npu_ram_sel_o  out  1  RAM-select grant; 1 = loader owns the NPU RAM write port
en_w_o  out  1  one-cycle line write strobe
region_o  out  clog2(REGION_CNT)  region of the current write
w_line_o  out  clog2(LINE_CNT)  line index of the current write
line_data_o  out  LINE_W  assembled line
busy_o  out  1  high in any state other than IDLE
done_o  out  1  one-cycle completion pulse
err_o  out  1  sticky framing error; cleared by the next accepted start

Behaviour:
- Reset: FSM to IDLE. All outputs 0, including s_ready_o. Word counter, line counter and line buffer cleared.
- Reset has priority in every state; asserting rst_i mid-load abandons the load with no further en_w_o.
- FSM states: IDLE, FILL, COMMIT, FINISH.
  - IDLE: on cfg_start_i, capture region and line count.
    - cfg_lines_i = 0: go to FINISH directly, with no writes and no grant.
    - cfg_lines_i > LINE_CNT: clamp to LINE_CNT.
    - Otherwise go to FILL with npu_ram_sel_o = 1.
  - FILL: s_ready_o = 1. WPL = LINE_W/WORD_W words per line. Word k lands in bits [k*WORD_W +: WORD_W], so the first word is at the LSBs. After word WPL-1, or any word with s_last_i = 1, go to COMMIT.
  - COMMIT: s_ready_o = 0, en_w_o = 1 for exactly one cycle, line_data_o = buffer, w_line_o = line counter.
    - Then clear the buffer and increment the line counter.
    - If the counter now equals the captured line count, or the line ended on s_last_i, go to FINISH; otherwise go back to FILL.
  - FINISH: npu_ram_sel_o = 0, done_o = 1 for one cycle, then IDLE.
- Latency: the last word of a line is accepted at edge N; en_w_o is high during cycle N+1; the next line's first word can be accepted at edge N+2.
- Early s_last_i (before the final word of the final line): the partial line is zero-padded above the last word, committed, and err_o is set.
- Missing s_last_i on the final word: the load still completes after the counted lines, and err_o is set.
- cfg_start_i while busy_o = 1: ignored; the captured configuration is unchanged.
- region_o, w_line_o and line_data_o hold their values outside COMMIT; only en_w_o qualifies them.

Optional Feature:
NPU_LOADER_READBACK_EN
- Defined: adds ports rd_req_i (1), rd_addr_i (RSLT_ADDR_W), r_rslt_addr_o (RSLT_ADDR_W), result_i (8), rd_valid_o (1) and rd_data_o (8).
  - A request is accepted only in IDLE and ignored otherwise.
  - The address is registered onto r_rslt_addr_o at edge N+1.
  - result_i is captured at edge N+2, with rd_valid_o = 1 for one cycle. busy_o is high during the readback.
  - Reset clears r_rslt_addr_o, rd_valid_o and rd_data_o.
- Undefined: none of these ports exist, and the behaviour is identical to the base block.

Decomposition:
- Shared package/defs holds:
  - region enumeration constants (REGION_IMG32 … REGION_RESULT);
  - FSM state encodings;
  - per-region active line widths (IMG_*/FLITER_*/WEIGHT_*/BIAS_*/RESULT_* spans).
- One sub-module, npu_line_packer: a word-to-line shift/assembly buffer with word counter, clear and full flag. The FSM stays in the top of the block.

Test Plan:
1. WORD_W=32, LINE_W=256, start region 0, lines=2, 16 words 0x1..0x10 with s_last_i on word 16 -> en_w_o on lines 0 and 1; line 0 = {0x8,…,0x1}; done_o pulses once; err_o = 0.
2. Stream stalls: s_valid_i toggled randomly, 1 line -> identical line_data_o; exactly one en_w_o; s_ready_o low in the COMMIT cycle.
3. lines=3 with s_last_i on word 10 -> lines 0 and 1 committed, line 1 upper 6 words zero; err_o = 1; no line-2 write.
4. cfg_lines_i = 0 -> done_o pulses one cycle after start; no en_w_o; npu_ram_sel_o stays 0. cfg_lines_i = 20 -> exactly 16 writes.
5. rst_i asserted after 5 words of line 1 -> next cycle all outputs 0, FSM IDLE; no further en_w_o. Repeated cfg_start_i while busy -> ignored.
6. (NPU_LOADER_READBACK_EN) rd_req_i with addr 0x2A in IDLE, result_i = 0x5C -> r_rslt_addr_o = 0x2A at N+1, rd_valid_o with rd_data_o = 0x5C at N+2. Request during a load -> ignored.
